cic_int24x2: RTL and testbench

Two-channel (I/Q) three-stage CIC integrator section with decimation strobe generation, sitting directly upstream of the 24-bit two-channel differentiator (comb) stage. It integrates both channels at the input rate in 40-bit modular accumulators and selects a 24-bit window of the last integrator. Every R input samples it presents channel 0 then channel 1 on one shared 24-bit bus with single-cycle enables `ce0`/`ce1`, matching the comb stage's multiplexed input.

---
 rtl/cic_int24x2.sv | 91 +++++++++
 tb/tb_cic_int24x2.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cic_int24x2.sv
// cic_int24x2: two-channel three-stage CIC integrator with decimation strobes and
// channel-multiplexed 24-bit output feeding the comb stage.
// Ports: clk, rst (sync, active-high); ce input valid; di/dq channel 0/1 samples;
// rate decimation ratio R (0/1 read as 2); shift output window LSB;
// q multiplexed output, ce0/ce1 one-cycle channel 0/1 strobes.
// Macro CIC_INT24X2_ROUND_EN: round half up at bit shift-1 instead of truncating.
module cic_int24x2 #(
  parameter int IW = 16,
  parameter int ACCW = 40,
  parameter int OW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [IW-1:0] di,
  input  logic [IW-1:0] dq,
  input  logic [7:0]    rate,
  input  logic [4:0]    shift,
  output logic [OW-1:0] q,
  output logic          ce0,
  output logic          ce1
);
  typedef enum logic [1:0] {IDLE, CH0, CH1} state_t;
  logic [1:0][IW-1:0] x;
  logic [1:0][ACCW-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [7:0] cnt_q, cnt_d, r_q, r_d, r_eff;
  logic [OW-1:0] snap_q, snap_d, q_q, q_d;
  logic dump_q, dump_d, ce0_q, ce0_d, ce1_q, ce1_d, term, go;
  state_t state_q, state_d;
  // Window is taken from a sign-extended copy so bits above ACCW-1 read as sign.
  function automatic logic [OW-1:0] sel(input logic [ACCW-1:0] s, input logic [4:0] sh);
    logic signed [ACCW:0] e;
    logic signed [ACCW:0] w;
    e = {s[ACCW-1], s};
`ifdef CIC_INT24X2_ROUND_EN
    if (sh != 5'd0) e = e + ((ACCW+1)'(1) << (sh - 5'd1));
`endif
    w = e >>> sh;
    return w[OW-1:0];
  endfunction
  assign x = {dq, di};
  assign q = q_q;
  assign ce0 = ce0_q;
  assign ce1 = ce1_q;
  always_comb begin
    r_eff = (rate < 8'd2) ? 8'd2 : rate;
    term = ce && (cnt_q == r_q - 8'd1);
    for (int c = 0; c < 2; c++) begin
      s1_d[c] = ce ? s1_q[c] + {{(ACCW-IW){x[c][IW-1]}}, x[c]} : s1_q[c];
      s2_d[c] = ce ? s2_q[c] + s1_q[c] : s2_q[c];
      s3_d[c] = ce ? s3_q[c] + s2_q[c] : s3_q[c];
    end
    cnt_d = !ce ? cnt_q : term ? 8'd0 : cnt_q + 8'd1;
    r_d = term ? r_eff : r_q;
    dump_d = term;
    // With R=2 a new dump can land while CH1 is finishing; start the next pair directly.
    go = dump_q && (state_q != CH0);
    state_d = go ? CH0 : (state_q == CH0) ? CH1 : IDLE;
    q_d = go ? sel(s3_q[0], shift) : (state_q == CH0) ? snap_q : q_q;
    snap_d = go ? sel(s3_q[1], shift) : snap_q;
    ce0_d = go;
    ce1_d = (state_q == CH0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      cnt_q <= '0;
      r_q <= r_eff;
      dump_q <= 1'b0;
      state_q <= IDLE;
      snap_q <= '0;
      q_q <= '0;
      ce0_q <= 1'b0;
      ce1_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      dump_q <= dump_d;
      state_q <= state_d;
      snap_q <= snap_d;
      q_q <= q_d;
      ce0_q <= ce0_d;
      ce1_q <= ce1_d;
    end
  end
endmodule

// File: tb/tb_cic_int24x2.sv
// tb_cic_int24x2: directed scoreboard bench for cic_int24x2.
module tb_cic_int24x2;
  logic clk = 0, rst = 1, ce = 0;
  logic [15:0] di = 0, dq = 0;
  logic [7:0] rate = 4;
  logic [4:0] shift = 0;
  logic [23:0] q;
  logic ce0, ce1;
  int tests = 0, fails = 0, cyc = 0, nce = 0, every = 1, ph = 0;
  bit en = 0, prev_ce0 = 0, seen;
  typedef struct {logic ch; logic [23:0] v; int t;} exp_t;
  exp_t sb[$];
  logic [23:0] g0[$], g1[$], g0n[$];
  logic [39:0] m1[2], m2[2], m3[2];
  int mcnt = 0, mr = 2;
  logic [23:0] rexp;

  cic_int24x2 dut (.clk(clk), .rst(rst), .ce(ce), .di(di), .dq(dq), .rate(rate),
                   .shift(shift), .q(q), .ce0(ce0), .ce1(ce1));

  always #5 clk = ~clk;

  function automatic logic [23:0] msel(input logic [39:0] s, input int sh);
    longint v;
    v = longint'($signed(s));
`ifdef CIC_INT24X2_ROUND_EN
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
    v = v >>> sh;
    return v[23:0];
  endfunction

  function automatic logic [23:0] at(input logic [23:0] qq[$], input int i);
    return (i < qq.size()) ? qq[i] : 'x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pushes expected strobe values/times on each terminal sample.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin m1[c] = 0; m2[c] = 0; m3[c] = 0; end
      mcnt = 0; nce = 0; mr = (rate < 2) ? 2 : int'(rate);
      sb.delete();
    end else if (ce) begin
      nce++;
      for (int c = 0; c < 2; c++) begin
        m3[c] = m3[c] + m2[c];
        m2[c] = m2[c] + m1[c];
        m1[c] = m1[c] + {{24{(c == 0) ? di[15] : dq[15]}}, (c == 0) ? di : dq};
      end
      if (mcnt == mr - 1) begin
        mcnt = 0;
        mr = (rate < 2) ? 2 : int'(rate);
        sb.push_back('{1'b0, msel(m3[0], int'(shift)), cyc + 1});
        sb.push_back('{1'b1, msel(m3[1], int'(shift)), cyc + 2});
      end else mcnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ce0 || ce1) begin
        check("strobe overlap", {31'b0, ce0 && ce1}, 0);
        check("q known", {31'b0, $isunknown(q)}, 0);
        if (sb.size() == 0) check("sb empty on strobe", {31'b0, ce1}, 32'hffffffff);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("strobe chan", {31'b0, ce1}, {31'b0, e.ch});
          check("strobe q", {8'b0, q}, {8'b0, e.v});
          check("strobe time", cyc, e.t);
        end
      end
      if (ce1) check("ce1 after ce0", {31'b0, prev_ce0}, 1);
      prev_ce0 = ce0;
    end
  end

  task automatic do_reset();
    rst = 1; ce = 0; en = 0;
    repeat (2) @(negedge clk);
    rst = 0; ph = 0;
    g0.delete(); g1.delete(); g0n.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ce0) begin g0.push_back(q); g0n.push_back(24'(nce)); end
      if (ce1) g1.push_back(q);
      ce = en && (ph % every == 0);
      ph++;
    end
  endtask

  initial begin
    // reset state
    rate = 4; shift = 0; di = 1; dq = 0;
    do_reset();
    check("rst q", {8'b0, q}, 0);
    check("rst ce0", {31'b0, ce0}, 0);
    check("rst ce1", {31'b0, ce1}, 0);
    // DC ramp
    en = 1; every = 1;
    run(14); en = 0; run(4);
    check("dc ce0 #1", {8'b0, at(g0, 0)}, 4);
    check("dc ce1 #1", {8'b0, at(g1, 0)}, 0);
    check("dc ce0 #2", {8'b0, at(g0, 1)}, 56);
    check("dc ce0 #3", {8'b0, at(g0, 2)}, 220);
    check("dc first ce0 ce count", {8'b0, at(g0n, 0)}, 5);
    // strobe ordering at R=2
    rate = 2; do_reset(); en = 1;
    run(20); en = 0; run(4);
    check("r2 ce0 pulses", g0.size(), 10);
    check("r2 ce1 pulses", g1.size(), 10);
    // sparse negative input
    rate = 3; di = 16'hffff; dq = 16'hffff; do_reset(); en = 1; every = 3;
    run(30); en = 0; run(4);
    check("sparse ce0 #1", {8'b0, at(g0, 0)}, {8'b0, 24'(-1)});
    check("sparse ce0 #2", {8'b0, at(g0, 1)}, {8'b0, 24'(-20)});
    check("sparse ce0 #3", {8'b0, at(g0, 2)}, {8'b0, 24'(-84)});
    check("sparse ce1 #1", {8'b0, at(g1, 0)}, {8'b0, 24'(-1)});
    check("sparse ce1 #3", {8'b0, at(g1, 2)}, {8'b0, 24'(-84)});
    check("sparse pairs", g0.size(), 3);
    // rate change mid-period
    rate = 4; di = 1; dq = 2; do_reset(); en = 1; every = 1;
    run(3); rate = 8;
    run(40); en = 0; run(4);
    check("rate chg ce0 #1 n", {8'b0, at(g0n, 0)}, 5);
    check("rate chg ce0 #2 n", {8'b0, at(g0n, 1)}, 13);
    check("rate chg ce0 #3 n", {8'b0, at(g0n, 2)}, 21);
    // rate 0 behaves as 2
    rate = 0; do_reset(); en = 1;
    run(8); en = 0; run(4);
    check("rate0 ce0 #1 n", {8'b0, at(g0n, 0)}, 3);
    check("rate0 ce0 #2 n", {8'b0, at(g0n, 1)}, 5);
    // wrap-around of the 40-bit integrators
    rate = 2; shift = 16; di = 16'h7fff; dq = 16'h8000; do_reset(); en = 1;
    run(1500); en = 0; run(4);
    check("wrap pairs", g0.size(), 750);
    // output rounding/truncation at shift=1 with s3=3
    rate = 4; shift = 1; di = 1; dq = 0; do_reset(); en = 1;
    run(2); di = 0;
    run(6); en = 0; run(4);
`ifdef CIC_INT24X2_ROUND_EN
    rexp = 2;
`else
    rexp = 1;
`endif
    check("shift1 s3=3", {8'b0, at(g0, 0)}, {8'b0, rexp});
    // reset on the ce0 cycle
    shift = 0; di = 1; do_reset(); ce = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = ce0; end
    check("pre-rst ce0", {31'b0, seen}, 1);
    rst = 1;
    @(negedge clk);
    check("mid rst ce0", {31'b0, ce0}, 0);
    check("mid rst ce1", {31'b0, ce1}, 0);
    check("mid rst q", {8'b0, q}, 0);
    rst = 0; ph = 0; every = 2; en = 1;
    g0.delete(); g1.delete(); g0n.delete();
    run(16); en = 0; run(4);
    check("post-rst first ce0 n", {8'b0, at(g0n, 0)}, 4);
    check("sb drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
